// File: rtl/coverfloat_txn_buffer.sv
// FP transaction capture buffer: per-channel hold registers, round-robin arbitration into a shared FIFO.
// Optional feature macro: COVERFLOAT_TXN_SEQ_EN adds a global capture sequence number on out_seq.

module coverfloat_txn_hold #(
  parameter int W      = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              grant,
  input  logic [W-1:0]      din,
  output logic              full,
  output logic [W-1:0]      dout,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              load
);
  // A slot being drained this cycle can take the new transaction on the same edge
  assign load = valid && (!full || grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      dout     <= '0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        dout <= din;
      end else if (grant) begin
        full <= 1'b0;
      end
      if (valid && !load && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

module coverfloat_txn_buffer #(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 8,
  parameter int OPERAND_W = 128,
  parameter int FMT_W     = 8,
  parameter int DROP_W    = 16,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*32-1:0]          ch_op,
  input  logic [NUM_CH*32-1:0]          ch_rm,
  input  logic [NUM_CH*32-1:0]          ch_exception_bits,
  input  logic [NUM_CH*OPERAND_W-1:0]   ch_a,
  input  logic [NUM_CH*OPERAND_W-1:0]   ch_b,
  input  logic [NUM_CH*OPERAND_W-1:0]   ch_c,
  input  logic [NUM_CH*OPERAND_W-1:0]   ch_result,
  input  logic [NUM_CH*FMT_W-1:0]       ch_a_fmt,
  input  logic [NUM_CH*FMT_W-1:0]       ch_b_fmt,
  input  logic [NUM_CH*FMT_W-1:0]       ch_c_fmt,
  input  logic [NUM_CH*FMT_W-1:0]       ch_result_fmt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic [31:0]                   out_op,
  output logic [31:0]                   out_rm,
  output logic [31:0]                   out_exception_bits,
  output logic [OPERAND_W-1:0]          out_a,
  output logic [OPERAND_W-1:0]          out_b,
  output logic [OPERAND_W-1:0]          out_c,
  output logic [OPERAND_W-1:0]          out_result,
  output logic [FMT_W-1:0]              out_a_fmt,
  output logic [FMT_W-1:0]              out_b_fmt,
  output logic [FMT_W-1:0]              out_c_fmt,
  output logic [FMT_W-1:0]              out_result_fmt,
`ifdef COVERFLOAT_TXN_SEQ_EN
  output logic [31:0]                   out_seq,
`endif
  output logic [NUM_CH*DROP_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH):0]        fifo_level
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
`ifdef COVERFLOAT_TXN_SEQ_EN
    logic [31:0]          seq;
`endif
    logic [31:0]          op;
    logic [31:0]          rm;
    logic [31:0]          exc;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [OPERAND_W-1:0] c;
    logic [OPERAND_W-1:0] result;
    logic [FMT_W-1:0]     a_fmt;
    logic [FMT_W-1:0]     b_fmt;
    logic [FMT_W-1:0]     c_fmt;
    logic [FMT_W-1:0]     result_fmt;
  } txn_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    txn_t            t;
  } ent_t;

  localparam int TW = $bits(txn_t);

  logic [NUM_CH-1:0] full, grant, load;
  txn_t [NUM_CH-1:0] din, held;

  logic [CH_W-1:0] rr_ptr, gnt_idx;
  logic            gnt_any, pop, can_push;
  logic [AW:0]     level;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  ent_t            mem [DEPTH];
  ent_t            head;

`ifdef COVERFLOAT_TXN_SEQ_EN
  logic [31:0]              seq_cnt, seq_nxt;
  logic [NUM_CH-1:0][31:0]  seq_off;

  // Simultaneous loads take consecutive numbers in channel-index order
  always_comb begin
    logic [31:0] s;
    s = seq_cnt;
    for (int i = 0; i < NUM_CH; i++) begin
      seq_off[i] = s;
      s = s + 32'(load[i]);
    end
    seq_nxt = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq_cnt <= '0;
    else        seq_cnt <= seq_nxt;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef COVERFLOAT_TXN_SEQ_EN
    assign din[i].seq      = seq_off[i];
`endif
    assign din[i].op         = ch_op[i*32 +: 32];
    assign din[i].rm         = ch_rm[i*32 +: 32];
    assign din[i].exc        = ch_exception_bits[i*32 +: 32];
    assign din[i].a          = ch_a[i*OPERAND_W +: OPERAND_W];
    assign din[i].b          = ch_b[i*OPERAND_W +: OPERAND_W];
    assign din[i].c          = ch_c[i*OPERAND_W +: OPERAND_W];
    assign din[i].result     = ch_result[i*OPERAND_W +: OPERAND_W];
    assign din[i].a_fmt      = ch_a_fmt[i*FMT_W +: FMT_W];
    assign din[i].b_fmt      = ch_b_fmt[i*FMT_W +: FMT_W];
    assign din[i].c_fmt      = ch_c_fmt[i*FMT_W +: FMT_W];
    assign din[i].result_fmt = ch_result_fmt[i*FMT_W +: FMT_W];

    coverfloat_txn_hold #(.W(TW), .DROP_W(DROP_W)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (ch_valid[i]),
      .grant    (grant[i]),
      .din      (din[i]),
      .full     (full[i]),
      .dout     (held[i]),
      .drop_cnt (drop_cnt[i*DROP_W +: DROP_W]),
      .load     (load[i])
    );
  end

  assign pop      = out_valid && out_ready;
  assign can_push = (level != (AW+1)'(DEPTH)) || pop;

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_any && full[idx] && can_push) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      if (gnt_any) begin
        mem[wr_ptr] <= ent_t'{ch: gnt_idx, t: held[gnt_idx]};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (int'(gnt_idx) == NUM_CH-1) ? '0 : gnt_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (gnt_any && !pop)      level <= level + 1'b1;
      else if (!gnt_any && pop) level <= level - 1'b1;
    end
  end

  assign head               = mem[rd_ptr];
  assign out_valid          = (level != '0);
  assign fifo_level         = level;
  assign out_ch             = head.ch;
  assign out_op             = head.t.op;
  assign out_rm             = head.t.rm;
  assign out_exception_bits = head.t.exc;
  assign out_a              = head.t.a;
  assign out_b              = head.t.b;
  assign out_c              = head.t.c;
  assign out_result         = head.t.result;
  assign out_a_fmt          = head.t.a_fmt;
  assign out_b_fmt          = head.t.b_fmt;
  assign out_c_fmt          = head.t.c_fmt;
  assign out_result_fmt     = head.t.result_fmt;
`ifdef COVERFLOAT_TXN_SEQ_EN
  assign out_seq            = head.t.seq;
`endif
endmodule

// File: tb/tb_coverfloat_txn_buffer.sv
// Scoreboard bench for coverfloat_txn_buffer: directed stimulus queues expected transactions,
// an independent monitor pops and compares on every accepted output beat.
`timescale 1ns/1ps
module tb_coverfloat_txn_buffer;
  localparam int NUM_CH = 2, DEPTH = 8, OW = 128, FW = 8, DW = 4, CW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH*32-1:0]   ch_op, ch_rm, ch_exc;
  logic [NUM_CH*OW-1:0]   ch_a, ch_b, ch_c, ch_res;
  logic [NUM_CH*FW-1:0]   ch_af, ch_bf, ch_cf, ch_rf;
  logic                   out_valid, out_ready;
  logic [CW-1:0]          out_ch;
  logic [31:0]            out_op, out_rm, out_exc;
  logic [OW-1:0]          out_a, out_b, out_c, out_res;
  logic [FW-1:0]          out_af, out_bf, out_cf, out_rf;
  logic [NUM_CH*DW-1:0]   drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef COVERFLOAT_TXN_SEQ_EN
  logic [31:0]            out_seq;
`endif

  coverfloat_txn_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .OPERAND_W(OW), .FMT_W(FW), .DROP_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid),
    .ch_op(ch_op), .ch_rm(ch_rm), .ch_exception_bits(ch_exc),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_result(ch_res),
    .ch_a_fmt(ch_af), .ch_b_fmt(ch_bf), .ch_c_fmt(ch_cf), .ch_result_fmt(ch_rf),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_op(out_op), .out_rm(out_rm), .out_exception_bits(out_exc),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_result(out_res),
    .out_a_fmt(out_af), .out_b_fmt(out_bf), .out_c_fmt(out_cf), .out_result_fmt(out_rf),
`ifdef COVERFLOAT_TXN_SEQ_EN
    .out_seq(out_seq),
`endif
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  typedef struct packed {
    logic [31:0]   seq;
    logic [CW-1:0] ch;
    logic [31:0]   op, rm, exc;
    logic [OW-1:0] a, b, c, res;
    logic [FW-1:0] af, bf, cf, rf;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic exp_t mk(input int ch, input int tag, input int seq);
    exp_t e;
    e.seq = 32'(seq);
    e.ch  = CW'(ch);
    e.op  = 32'h100 * ch + 32'(tag);
    e.rm  = 32'(tag % 5);
    e.exc = 32'h1 << (tag % 5);
    e.a   = {32'hAAAA0000 + 32'(tag), 64'h0123_4567_89AB_CDEF, 32'(ch)};
    e.b   = ~e.a;
    e.c   = {4{32'(tag * 3)}};
    e.res = {e.a[63:0], e.c[63:0]};
    e.af  = FW'(tag + 1);
    e.bf  = FW'(tag + 2);
    e.cf  = FW'(tag + 3);
    e.rf  = FW'(tag + 4);
    return e;
  endfunction

  task automatic drive(input exp_t e);
    int i;
    i = int'(e.ch);
    ch_valid[i]          = 1'b1;
    ch_op[i*32 +: 32]    = e.op;
    ch_rm[i*32 +: 32]    = e.rm;
    ch_exc[i*32 +: 32]   = e.exc;
    ch_a[i*OW +: OW]     = e.a;
    ch_b[i*OW +: OW]     = e.b;
    ch_c[i*OW +: OW]     = e.c;
    ch_res[i*OW +: OW]   = e.res;
    ch_af[i*FW +: FW]    = e.af;
    ch_bf[i*FW +: FW]    = e.bf;
    ch_cf[i*FW +: FW]    = e.cf;
    ch_rf[i*FW +: FW]    = e.rf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ch_valid = '0;
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted beat must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got ch %0d op %h with empty scoreboard at %0t", out_ch, out_op, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_ch",   128'(out_ch), 128'(e.ch));
        chk("sb_op",   128'(out_op), 128'(e.op));
        chk("sb_rm",   128'(out_rm), 128'(e.rm));
        chk("sb_exc",  128'(out_exc), 128'(e.exc));
        chk("sb_a",    out_a, e.a);
        chk("sb_b",    out_b, e.b);
        chk("sb_c",    out_c, e.c);
        chk("sb_res",  out_res, e.res);
        chk("sb_fmts", 128'({out_af, out_bf, out_cf, out_rf}), 128'({e.af, e.bf, e.cf, e.rf}));
`ifdef COVERFLOAT_TXN_SEQ_EN
        chk("sb_seq",  128'(out_seq), 128'(e.seq));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    ch_valid = '0; ch_op = '0; ch_rm = '0; ch_exc = '0;
    ch_a = '0; ch_b = '0; ch_c = '0; ch_res = '0;
    ch_af = '0; ch_bf = '0; ch_cf = '0; ch_rf = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_level",     128'(fifo_level), 128'(0));
    chk("rst_drop",      128'(drop_cnt), 128'(0));
    chk("rst_out_op",    128'(out_op), 128'(0));
    chk("rst_out_a",     out_a, 128'(0));
    rst_n = 1'b1;

    // Single transaction latency
    do_reset();
    out_ready = 1'b1;
    step();
    e = mk(0, 1, 0);
    e.op = 32'h5; e.a = 128'h3F800000; e.rf = 8'h1;
    drive(e); sbq.push_back(e);
    step(); ch_valid = '0;
    chk("t1_valid_c1", 128'(out_valid), 128'(0));
    step();
    chk("t1_valid_c2", 128'(out_valid), 128'(1));
    step();
    chk("t1_valid_c3", 128'(out_valid), 128'(0));

    // Round robin: two rounds, order must restart at channel 0
    do_reset();
    out_ready = 1'b1;
    step();
    for (int r = 0; r < 2; r++) begin
      e = mk(0, 10 + 2*r, 2*r);     drive(e); sbq.push_back(e);
      e = mk(1, 11 + 2*r, 2*r + 1); drive(e); sbq.push_back(e);
      step(); ch_valid = '0;
      step();
      chk("rr_valid_first", 128'(out_valid), 128'(1));
      step();
      chk("rr_valid_second", 128'(out_valid), 128'(1));
      step();
    end

    // Overflow on channel 1, then simultaneous push/pop at full
    do_reset();
    out_ready = 1'b0;
    step();
    for (int t = 0; t < 12; t++) begin
      e = mk(1, 20 + t, t);
      drive(e);
      if (t < 9) sbq.push_back(e);
      step();
    end
    ch_valid = '0;
    chk("ovf_level", 128'(fifo_level), 128'(8));
    chk("ovf_drop1", 128'(drop_cnt[1*DW +: DW]), 128'(3));
    chk("ovf_drop0", 128'(drop_cnt[0 +: DW]), 128'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pushpop_level", 128'(fifo_level), 128'(8));
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) step();
    chk("drain_done", 128'(out_valid), 128'(0));
    chk("drain_level", 128'(fifo_level), 128'(0));
    chk("drain_sb_empty", 128'(sbq.size()), 128'(0));

    // Drop counter saturation: 29 offers, 9 captured, 20 dropped
    do_reset();
    out_ready = 1'b0;
    step();
    for (int t = 0; t < 29; t++) begin
      drive(mk(1, t, 0));
      step();
    end
    ch_valid = '0;
    chk("sat_drop1", 128'(drop_cnt[1*DW +: DW]), 128'(15));
    chk("sat_drop0", 128'(drop_cnt[0 +: DW]), 128'(0));

    // Reset mid-stream with five entries queued
    do_reset();
    out_ready = 1'b0;
    step();
    for (int t = 0; t < 5; t++) begin
      drive(mk(0, 40 + t, 0));
      step();
    end
    ch_valid = '0;
    step();
    chk("mid_level_before", 128'(fifo_level), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_level", 128'(fifo_level), 128'(0));
    chk("mid_rst_drop",  128'(drop_cnt), 128'(0));
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    e = mk(0, 77, 0); drive(e); sbq.push_back(e);
    step(); ch_valid = '0;
    for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
    step();
    chk("final_sb_empty", 128'(sbq.size()), 128'(0));
    chk("final_level", 128'(fifo_level), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/coverfloat_txn_buffer.md
# coverfloat_txn_buffer

- Multi-channel transaction capture buffer for FP coverage collection.
- Samples completed FP operations from NUM_CH independent DUT result ports. Each port carries op, rm, three operands with formats, result with format, and exception bits.
- Arbitrates captured operations round-robin into one shared FIFO and presents them, tagged with their channel, to the coverage sampler on a valid/ready stream.
- DUT ports cannot be back-pressured. Overflow is counted per channel, never stalled.

## Interface

Parameters:
- NUM_CH, 2 — number of DUT channels, ≥1; CH_W = max(1, $clog2(NUM_CH)).
- DEPTH, 8 — shared FIFO entries, power of two, ≥2.
- OPERAND_W, 128 — operand/result width.
- FMT_W, 8 — format code width.
- DROP_W, 16 — per-channel drop counter width.

Ports. Channel buses are flattened; channel i occupies slice i:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ch_valid  input  NUM_CH  channel i presents a completed operation this cycle.
- ch_op, ch_rm, ch_exception_bits  input  NUM_CH*32 each  opcode, rounding mode, exception flags.
- ch_a, ch_b, ch_c, ch_result  input  NUM_CH*OPERAND_W each  operands and result.
- ch_a_fmt, ch_b_fmt, ch_c_fmt, ch_result_fmt  input  NUM_CH*FMT_W each  formats.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  sampler accepts head.
- out_ch  output  CH_W  source channel of head.
- out_op, out_rm, out_exception_bits, out_a, out_b, out_c, out_result, out_a_fmt, out_b_fmt, out_c_fmt, out_result_fmt  output  single-channel widths  head transaction fields.
- out_seq  output  32  global capture sequence number (COVERFLOAT_TXN_SEQ_EN only).
- drop_cnt  output  NUM_CH*DROP_W  saturating per-channel drop counters.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

Hold stage:
- One holding register plus a full flag per channel.
- When ch_valid[i]=1, the full fields load at the edge if hold i is empty or is granted in that same cycle. A refill-while-drain loads the new transaction.
- Otherwise the new transaction is dropped, the older held one is kept, and drop_cnt[i] increments, saturating at all-ones.

Arbiter:
- Round-robin pointer rr_ptr, reset 0.
- Each cycle the grant goes to the first full hold channel searching from rr_ptr upward with wrap.
- A grant is issued only if the FIFO can accept: it is not full, or out_valid && out_ready in that cycle.
- On grant, rr_ptr ← (granted+1) mod NUM_CH. Without a grant, rr_ptr is unchanged.
- At most one push per cycle.

FIFO:
- DEPTH entries, each holding {channel, all fields[, seq]}.
- out_* is driven from the head entry register.
- out_valid = (level≠0).
- Pop occurs on out_valid && out_ready.
- Push and pop in the same cycle leave the level unchanged; this is legal at full and at level 1.
- Pointers wrap modulo DEPTH.
- Head data is stable while out_valid && !out_ready.

## Timing

- Reset (async assert, sync-released by the environment):
  - all hold flags 0, rr_ptr 0, level 0, pointers 0, drop_cnt 0, out_seq counter 0;
  - out_valid 0; out_* data 0.
- Latency: ch_valid at cycle 0 → held at edge 1 → pushed at edge 2 → out_valid=1 in cycle 2, if no contention and FIFO not full.
- Sustained throughput: one transaction per cycle total. With NUM_CH channels each valid every cycle, per-channel drops are expected.
- Reset mid-operation discards all held and FIFO contents immediately. Drop counters clear.
- fifo_level reflects state after the last edge; it is registered.

## Configuration

- COVERFLOAT_TXN_SEQ_EN defined:
  - a 32-bit counter (wraps 0xFFFFFFFF→0) increments on every hold-register load;
  - its value is captured with the transaction and presented on out_seq;
  - dropped transactions do not consume a number.
- COVERFLOAT_TXN_SEQ_EN undefined: the out_seq port and counter are absent. Behaviour is otherwise identical.

## Test plan

- Single txn: NUM_CH=2; ch_valid[0]=1 for one cycle with op=0x5, a=0x3F800000, result_fmt=1 → out_valid rises cycle 2, out_ch=0, fields match; with out_ready=1, out_valid falls cycle 3.
- Round-robin: both channels valid in cycle 0 only → out_ch=0 then out_ch=1 on consecutive cycles; rr_ptr ends at 0.
- Overflow: out_ready=0, DEPTH=8, ch 0 valid 12 consecutive cycles → fifo_level=8, drop_cnt[0]=3, hold 0 full; drain all → 9 transactions out in capture order.
- Full push/pop: FIFO full, hold 1 full, out_ready=1 for one cycle → one pop and one push on the same edge, level stays 8.
- Saturation: DROP_W=4, force 20 drops on ch 1 → drop_cnt[1]=15.
- Reset mid-stream: assert rst_n=0 with level=5 → out_valid=0 and level=0 asynchronously. With COVERFLOAT_TXN_SEQ_EN, the first post-reset txn has out_seq=0.
